morse_timing_ctrl: RTL and testbench

MORSE_TIMING_CTRL -- requirements
Module: morse_timing_ctrl

---
 rtl/morse_timing_ctrl_if.sv | 19 +
 rtl/morse_timing_ctrl.sv | 165 ++++++++++++++++
 tb/tb_morse_timing_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_timing_ctrl_if
//  Description : Configuration handshake bundle for morse_timing_ctrl.
//                The master offers a unit time, and the slave accepts it
//                when cfg_valid and cfg_ready are both high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface morse_timing_ctrl_if #(
   parameter int unsigned UNIT_W = 10
);
   logic [UNIT_W-1:0] cfg_unit;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_unit, output cfg_valid, input  cfg_ready);
   modport slave  (input  cfg_unit, input  cfg_valid, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/morse_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : morse_timing_ctrl
//  Description : Morse keyer timing core. A free-running prescaler produces
//                a 1 ms tick, and four independent timers (button, dash,
//                inter-character, word) count multiples of a configurable
//                unit time. Each timer raises a sticky expiry flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_timing_ctrl #(
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned UNIT_W       = 10,
   parameter int unsigned DEFAULT_UNIT = 100,
   parameter int unsigned BTN_UNITS    = 10,
   parameter int unsigned DASH_UNITS   = 2,
   parameter int unsigned INTER_UNITS  = 3,
   parameter int unsigned WORD_UNITS   = 7
) (
   input  wire logic              clk_100MHz,
   input  wire logic              reset_n,
   morse_timing_ctrl_if.slave     cfg,
   input  wire logic              btn_to_res,
   input  wire logic              dash_to_res,
   input  wire logic              inter_to_res,
   input  wire logic              word_to_res,
   output logic                   btn_to,
   output logic                   dash_to,
   output logic                   inter_to,
   output logic                   word_to,
   output logic [UNIT_W-1:0]      unit_cur,
   output logic                   busy
);

   localparam int unsigned c_pw = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned c_cw = UNIT_W + 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } tmr_state_t;

   logic [c_pw-1:0]   presc_q, presc_d;
   logic              w_tick;
   logic [UNIT_W-1:0] unit_q, unit_d;
   logic [3:0]        w_res;
   logic [3:0]        w_run;
   logic [3:0]        w_flag;
   logic              w_busy;
   logic              w_accept;

   // Timer index order: 0 = button, 1 = dash, 2 = inter-character, 3 = word.
   assign w_res = {word_to_res, inter_to_res, dash_to_res, btn_to_res};

   // The tick is decoded from the prescaler register, so it adds no input-to-output path.
   assign w_tick = (presc_q == c_pw'(TICK_DIV - 1));

   // Prescaler next value: free-running count that wraps after the tick cycle.
   always_comb begin
      presc_d = presc_q + c_pw'(1);
      if (w_tick) begin
         presc_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk_100MHz) begin
      if (!reset_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // Config is accepted only while every timer is out of RUN; zero is promoted to one.
   assign w_busy   = |w_run;
   assign w_accept = cfg.cfg_valid && !w_busy;

   // Unit-time next value.
   always_comb begin
      unit_d = unit_q;
      if (w_accept) begin
         unit_d = (cfg.cfg_unit == '0) ? UNIT_W'(1) : cfg.cfg_unit;
      end
   end

   // Unit-time register.
   always_ff @(posedge clk_100MHz) begin
      if (!reset_n) begin
         unit_q <= UNIT_W'(DEFAULT_UNIT);
      end else begin
         unit_q <= unit_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_tmr
         localparam int unsigned c_units_i = (gi == 0) ? BTN_UNITS  :
                                             (gi == 1) ? DASH_UNITS :
                                             (gi == 2) ? INTER_UNITS : WORD_UNITS;
         localparam logic [c_cw-1:0] c_units = c_cw'(c_units_i);

         tmr_state_t      state_q, state_d;
         logic [c_cw-1:0] cnt_q, cnt_d;
         logic            flag_q, flag_d;
         logic [c_cw-1:0] w_load;

         // Reload uses the unit value registered before any same-cycle config update.
         assign w_load = c_units * {4'b0000, unit_q};

         // Timer next state: restart beats tick, RUN counts ticks down, DONE holds.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            flag_d  = flag_q;
            if (w_res[gi]) begin
               state_d = ST_RUN;
               cnt_d   = w_load;
               flag_d  = 1'b0;
            end else begin
               case (state_q)
                  ST_RUN: begin
                     if (w_tick) begin
                        cnt_d = cnt_q - c_cw'(1);
                        if (cnt_q == c_cw'(1)) begin
                           state_d = ST_DONE;
                           flag_d  = 1'b1;
                        end
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end

         // Timer state, counter and sticky flag registers.
         always_ff @(posedge clk_100MHz) begin
            if (!reset_n) begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               flag_q  <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               flag_q  <= flag_d;
            end
         end

         assign w_run[gi]  = (state_q == ST_RUN);
         assign w_flag[gi] = flag_q;
      end
   endgenerate

   assign btn_to        = w_flag[0];
   assign dash_to       = w_flag[1];
   assign inter_to      = w_flag[2];
   assign word_to       = w_flag[3];
   assign unit_cur      = unit_q;
   assign busy          = w_busy;
   assign cfg.cfg_ready = !w_busy;

endmodule
`default_nettype wire

// File: tb/tb_morse_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_timing_ctrl
//  Description : Self-checking bench for morse_timing_ctrl with TICK_DIV = 4.
//                Directed scenarios plus a randomized run against a
//                deadline-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_timing_ctrl;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] tb_res = 4'b0000;
   logic       btn_to, dash_to, inter_to, word_to, busy;
   logic [9:0] unit_cur;
   logic [3:0] flags;
   int         checks = 0;
   int         errors = 0;

   int c_units[4] = '{10, 2, 3, 7};

   morse_timing_ctrl_if #(.UNIT_W(10)) cfg_if ();

   morse_timing_ctrl #(
      .TICK_DIV(TD), .UNIT_W(10), .DEFAULT_UNIT(100),
      .BTN_UNITS(10), .DASH_UNITS(2), .INTER_UNITS(3), .WORD_UNITS(7)
   ) dut (
      .clk_100MHz  (clk),
      .reset_n     (reset_n),
      .cfg         (cfg_if.slave),
      .btn_to_res  (tb_res[0]),
      .dash_to_res (tb_res[1]),
      .inter_to_res(tb_res[2]),
      .word_to_res (tb_res[3]),
      .btn_to      (btn_to),
      .dash_to     (dash_to),
      .inter_to    (inter_to),
      .word_to     (word_to),
      .unit_cur    (unit_cur),
      .busy        (busy)
   );

   assign flags = {word_to, inter_to, dash_to, btn_to};

   always #5 clk = ~clk;

   // Reference model: edge k is the k-th edge after reset; ticks fall on k % TD == TD-1.
   logic [3:0] m_run, m_flag;
   int         m_dl[4];
   int         m_k;
   logic [9:0] m_unit;

   function automatic int f_deadline(input int k, input int n);
      int x;
      x = k + 1;
      return x + (TD - 1 - (x % TD)) + (n - 1) * TD;
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_k    <= 0;
         m_run  <= '0;
         m_flag <= '0;
         m_unit <= 10'd100;
      end else begin
         m_k <= m_k + 1;
         if (cfg_if.cfg_valid && (m_run == 4'b0000))
            m_unit <= (cfg_if.cfg_unit == 10'd0) ? 10'd1 : cfg_if.cfg_unit;
         for (int i = 0; i < 4; i++) begin
            if (tb_res[i]) begin
               m_dl[i]   <= f_deadline(m_k, c_units[i] * int'(m_unit));
               m_run[i]  <= 1'b1;
               m_flag[i] <= 1'b0;
            end else if (m_run[i] && (m_k == m_dl[i])) begin
               m_run[i]  <= 1'b0;
               m_flag[i] <= 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic do_reset();
      reset_n          = 1'b0;
      tb_res           = '0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_unit  = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic do_cfg(input logic [9:0] u);
      cfg_if.cfg_unit  = u;
      cfg_if.cfg_valid = 1'b1;
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] m);
      tb_res = m;
      @(negedge clk);
      tb_res = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      tb_res  = 4'b1111;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_unit  = 10'd9;
      repeat (2) @(negedge clk);
      tb_res = '0;
      cfg_if.cfg_valid = 1'b0;
      reset_n = 1'b1;
      checks++;
      if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
      checks++;
      if (unit_cur !== 10'd100) begin errors++; $display("FAIL reset_unit got %0d want 100", unit_cur); end
      checks++;
      if (cfg_if.cfg_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_ready got ready=%b busy=%b want 1/0", cfg_if.cfg_ready, busy);
      end
   endtask

   task automatic test_dash();
      int cyc;
      int bad;
      do_cfg(10'd2);
      checks++;
      if (unit_cur !== 10'd2) begin errors++; $display("FAIL dash_cfg unit got %0d want 2", unit_cur); end
      pulse(4'b0010);
      cyc = 1;
      bad = 0;
      while (dash_to !== 1'b1 && cyc < 200) begin
         if (busy !== 1'b1 || cfg_if.cfg_ready !== 1'b0) bad++;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL dash_busy got %0d bad cycles want 0", bad); end
      checks++;
      if (cyc - 1 < 13 || cyc - 1 > 16) begin errors++; $display("FAIL dash_expiry got %0d cycles want 13..16", cyc - 1); end
      checks++;
      if (busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
         errors++; $display("FAIL dash_idle got busy=%b ready=%b want 0/1", busy, cfg_if.cfg_ready);
      end
   endtask

   task automatic test_cfg_zero();
      int cyc;
      do_cfg(10'd0);
      checks++;
      if (unit_cur !== 10'd1) begin errors++; $display("FAIL cfg_zero unit got %0d want 1", unit_cur); end
      pulse(4'b0100);
      cyc = 1;
      while (inter_to !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc - 1 < 9 || cyc - 1 > 12) begin errors++; $display("FAIL inter_expiry got %0d cycles want 9..12", cyc - 1); end
      checks++;
      if (dash_to !== 1'b1) begin errors++; $display("FAIL dash_sticky got %b want 1", dash_to); end
   endtask

   task automatic test_restart();
      int cyc;
      int early;
      do_cfg(10'd2);
      pulse(4'b0001);
      early = 0;
      repeat (9) begin
         @(negedge clk);
         if (btn_to !== 1'b0) early++;
      end
      pulse(4'b0001);
      cyc = 1;
      while (btn_to !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
      checks++;
      if (early != 0) begin errors++; $display("FAIL btn_early got %0d want 0", early); end
      checks++;
      if (cyc - 1 < 77 || cyc - 1 > 80) begin errors++; $display("FAIL btn_restart got %0d cycles want 77..80", cyc - 1); end
   endtask

   task automatic test_cfg_hold();
      int cyc;
      int bad;
      pulse(4'b1000);
      cfg_if.cfg_unit  = 10'd5;
      cfg_if.cfg_valid = 1'b1;
      cyc = 1;
      bad = 0;
      while (word_to !== 1'b1 && cyc < 400) begin
         if (unit_cur !== 10'd2 || cfg_if.cfg_ready !== 1'b0) bad++;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL hold_no_accept got %0d bad cycles want 0", bad); end
      checks++;
      if (cyc - 1 < 53 || cyc - 1 > 56) begin errors++; $display("FAIL word_expiry got %0d cycles want 53..56", cyc - 1); end
      checks++;
      if (unit_cur !== 10'd2 || cfg_if.cfg_ready !== 1'b1) begin
         errors++; $display("FAIL hold_at_done got unit=%0d ready=%b want 2/1", unit_cur, cfg_if.cfg_ready);
      end
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
      checks++;
      if (unit_cur !== 10'd5) begin errors++; $display("FAIL hold_accept got %0d want 5", unit_cur); end
   endtask

   task automatic test_cfg_same_cycle();
      int cyc;
      do_cfg(10'd2);
      cfg_if.cfg_unit  = 10'd5;
      cfg_if.cfg_valid = 1'b1;
      tb_res = 4'b0010;
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
      tb_res = '0;
      checks++;
      if (unit_cur !== 10'd5 || cfg_if.cfg_ready !== 1'b0) begin
         errors++; $display("FAIL same_cycle got unit=%0d ready=%b want 5/0", unit_cur, cfg_if.cfg_ready);
      end
      cyc = 1;
      while (dash_to !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc - 1 < 13 || cyc - 1 > 16) begin errors++; $display("FAIL same_cycle_dash got %0d cycles want 13..16", cyc - 1); end
   endtask

   task automatic test_reset_mid_run();
      int rose;
      pulse(4'b1111);
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
      reset_n = 1'b0;
      tb_res  = 4'b0110;
      cfg_if.cfg_unit  = 10'd7;
      cfg_if.cfg_valid = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      tb_res  = '0;
      cfg_if.cfg_valid = 1'b0;
      checks++;
      if (flags !== 4'b0000 || unit_cur !== 10'd100 || cfg_if.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrun_reset got flags=%b unit=%0d ready=%b want 0000/100/1", flags, unit_cur, cfg_if.cfg_ready);
      end
      rose = 0;
      repeat (300) begin
         @(negedge clk);
         if (flags !== 4'b0000 || busy !== 1'b0) rose++;
      end
      checks++;
      if (rose != 0) begin errors++; $display("FAIL midrun_quiet got %0d active cycles want 0", rose); end
   endtask

   task automatic test_random();
      int bad_flags, bad_ctl, bad_unit;
      logic [3:0] r;
      do_reset();
      do_cfg(10'($urandom_range(0, 3)));
      bad_flags = 0; bad_ctl = 0; bad_unit = 0;
      for (int n = 0; n < 3000; n++) begin
         checks++;
         if (flags !== m_flag) begin
            errors++; bad_flags++;
            if (bad_flags < 5) $display("FAIL rand_flags cyc %0d got %b want %b", n, flags, m_flag);
         end
         checks++;
         if (busy !== (m_run != 4'b0000) || cfg_if.cfg_ready !== (m_run == 4'b0000)) begin
            errors++; bad_ctl++;
            if (bad_ctl < 5) $display("FAIL rand_busy cyc %0d got busy=%b ready=%b want busy=%b", n, busy, cfg_if.cfg_ready, (m_run != 4'b0000));
         end
         checks++;
         if (unit_cur !== m_unit) begin
            errors++; bad_unit++;
            if (bad_unit < 5) $display("FAIL rand_unit cyc %0d got %0d want %0d", n, unit_cur, m_unit);
         end
         for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 99) < 2);
         tb_res = r;
         cfg_if.cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_if.cfg_unit  = 10'($urandom_range(0, 3));
         @(negedge clk);
      end
      tb_res = '0;
      cfg_if.cfg_valid = 1'b0;
   endtask

   initial begin
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_unit  = '0;
      @(negedge clk);
      test_reset();
      test_dash();
      test_cfg_zero();
      test_restart();
      test_cfg_hold();
      test_cfg_same_cycle();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
